ft600_rx_ctrl: RTL

FT600_RX_CTRL -- requirements
Module: ft600_rx_ctrl

---
 rtl/ft600_rx_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ft600_rx_ctrl.sv
// FT600 245-mode receive controller: bursts words off the FT600 bus into a skid buffer and drains them into an async FIFO write port.
// Capture-to-w_en is one cycle. Downstream w_full stalls the drain, and the burst stops while one skid slot is still free.
module ft600_rx_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  w_clk,
  input  logic                  rst,
  input  logic                  ft_rxf_n,
  input  logic [DATA_WIDTH-1:0] ft_data,
  output logic                  ft_oe_n,
  output logic                  ft_rd_n,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_in,
  input  logic                  w_full,
  output logic [31:0]           rx_words
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ENTER_MAX = CNT_W'(SKID_DEPTH - 2);
  localparam logic [CNT_W-1:0] STOP_AT   = CNT_W'(SKID_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OE,
    ST_READ,
    ST_TURN
  } state_t;

  state_t                  state_q, state_d;
  logic                    oe_n_q, oe_n_d;
  logic                    rd_n_q, rd_n_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             rx_words_q, rx_words_d;
  logic [DATA_WIDTH-1:0]   skid_mem [SKID_DEPTH];

  logic push;
  logic pop;

  // Capture keys off the registered strobe the FT600 actually saw this cycle.
  assign push = !rd_n_q && !ft_rxf_n;
  assign pop  = (cnt_q != '0) && !w_full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rx_words_d = rx_words_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rx_words_d = rx_words_q + 32'd1;
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!ft_rxf_n && (cnt_q <= ENTER_MAX)) begin
          state_d = ST_OE;
        end
      end
      ST_OE: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        // Stopping at DEPTH-1 leaves room for the word already in flight.
        if (ft_rxf_n || (cnt_d >= STOP_AT)) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    oe_n_d = !((state_d == ST_OE) || (state_d == ST_READ));
    rd_n_d = (state_d != ST_READ);
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rx_words_q <= '0;
    end else begin
      state_q    <= state_d;
      oe_n_q     <= oe_n_d;
      rd_n_q     <= rd_n_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rx_words_q <= rx_words_d;
    end
  end

  // Storage has no reset; validity is tracked entirely by cnt_q.
  always_ff @(posedge w_clk) begin
    if (!rst && push) begin
      skid_mem[wr_ptr_q] <= ft_data;
    end
  end

  assign ft_oe_n  = oe_n_q;
  assign ft_rd_n  = rd_n_q;
  assign w_en     = pop;
  assign w_in     = skid_mem[rd_ptr_q];
  assign rx_words = rx_words_q;

  a_no_overflow : assert property (@(posedge w_clk) disable iff (rst)
    !(push && !pop && (cnt_q == CNT_W'(SKID_DEPTH))));

endmodule
